// File: rtl/seg_readback_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seg_readback_decoder
// Brief   : Readback monitor for the 4-digit active-low seven-segment bus.
//           Waits for a stable word, decodes it to 0..99 and publishes it
//           with a valid/ack handshake. Optional macro SEG_DEC_ERRCNT_EN adds
//           a saturating error counter port.
// Revision: 1.0 - initial release
// ============================================================================
module seg_readback_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int ERRCNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [27:0]         seg_in,
    input  logic                val_ack,
    output logic [6:0]          val_value,
    output logic                val_err,
    output logic                val_valid,
    output logic                busy
`ifdef SEG_DEC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    localparam int                 c_cnt_w    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(STABLE_CYCLES);
    localparam logic [6:0]         c_zero_seg = 7'b0000001;

    typedef enum logic [1:0] {
        ST_SETTLE   = 2'd0,
        ST_PUBLISH  = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_STEADY   = 2'd3
    } state_t;

    generate
        if (STABLE_CYCLES < 2 || STABLE_CYCLES > 1023 || ERRCNT_W < 1) begin : g_param_check
            $error("seg_readback_decoder: parameter out of range");
        end
    endgenerate

    // Returns {illegal, digit}
    function automatic logic [4:0] f_digit(input logic [6:0] s);
        case (s)
            7'b0000001: f_digit = {1'b0, 4'd0};
            7'b1001111: f_digit = {1'b0, 4'd1};
            7'b0010010: f_digit = {1'b0, 4'd2};
            7'b0000110: f_digit = {1'b0, 4'd3};
            7'b1001100: f_digit = {1'b0, 4'd4};
            7'b0100100: f_digit = {1'b0, 4'd5};
            7'b0100000: f_digit = {1'b0, 4'd6};
            7'b0001111: f_digit = {1'b0, 4'd7};
            7'b0000000: f_digit = {1'b0, 4'd8};
            7'b0000100: f_digit = {1'b0, 4'd9};
            default:    f_digit = {1'b1, 4'd0};
        endcase
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [27:0]          r_seg_q;
    logic [27:0]          r_seg_prev;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_first;
    logic                 r_dirty;
    logic [6:0]           r_cand_value;
    logic                 r_cand_err;
    logic [6:0]           r_val_value;
    logic                 r_val_err;
    logic [6:0]           r_last_value;
    logic                 r_last_err;

    logic [4:0]           w_tens;
    logic [4:0]           w_ones;
    logic                 w_err;
    logic [6:0]           w_tens_x10;
    logic [6:0]           w_sum;
    logic [6:0]           w_value;
    logic                 w_stable;
    logic                 w_seg_diff;
    logic                 w_differs;

    assign w_tens     = f_digit(r_seg_q[27:21]);
    assign w_ones     = f_digit(r_seg_q[20:14]);
    assign w_err      = w_tens[4] | w_ones[4]
                      | (r_seg_q[13:7] != c_zero_seg) | (r_seg_q[6:0] != c_zero_seg);
    assign w_tens_x10 = {w_tens[3:0], 3'b000} + {2'b00, w_tens[3:0], 1'b0};
    assign w_sum      = w_tens_x10 + {3'b000, w_ones[3:0]};
    assign w_value    = w_err ? 7'd0 : w_sum;
    assign w_stable   = (r_cnt == c_cnt_max);
    assign w_seg_diff = (r_seg_q != r_seg_prev);
    assign w_differs  = r_first | ({w_err, w_value} != {r_last_err, r_last_value});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SETTLE: begin
                if (w_stable) begin
                    w_state_nxt = w_differs ? ST_PUBLISH : ST_STEADY;
                end
            end
            ST_PUBLISH: w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (val_ack) begin
                    w_state_nxt = (r_dirty | w_seg_diff) ? ST_SETTLE : ST_STEADY;
                end
            end
            ST_STEADY: begin
                if (w_seg_diff) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SETTLE;
            r_seg_q      <= '1;
            r_seg_prev   <= '1;
            r_cnt        <= '0;
            r_first      <= 1'b1;
            r_dirty      <= 1'b0;
            r_cand_value <= '0;
            r_cand_err   <= 1'b0;
            r_val_value  <= '0;
            r_val_err    <= 1'b0;
            r_last_value <= '0;
            r_last_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seg_q    <= seg_in;
            r_seg_prev <= r_seg_q;
            // Counter tracks the seg_q/seg_prev pair as it will be after this edge
            if (seg_in != r_seg_q) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            // Snapshot the decode so a change during PUBLISH cannot corrupt it
            if (r_state == ST_SETTLE && w_stable) begin
                r_cand_value <= w_value;
                r_cand_err   <= w_err;
            end
            if (r_state == ST_PUBLISH) begin
                r_val_value  <= r_cand_value;
                r_val_err    <= r_cand_err;
                r_last_value <= r_cand_value;
                r_last_err   <= r_cand_err;
                r_first      <= 1'b0;
                r_dirty      <= w_seg_diff;
            end else if (r_state == ST_WAIT_ACK) begin
                r_dirty <= r_dirty | w_seg_diff;
            end
        end
    end

`ifdef SEG_DEC_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_state == ST_PUBLISH && r_cand_err && r_err_count != '1) begin
            r_err_count <= r_err_count + ERRCNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

    assign val_value = r_val_value;
    assign val_err   = r_val_err;
    assign val_valid = (r_state == ST_WAIT_ACK);
    assign busy      = (r_state == ST_SETTLE) || (r_state == ST_PUBLISH);

endmodule
`default_nettype wire

// File: tb/tb_seg_readback_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_seg_readback_decoder
// Brief   : Self-checking bench for seg_readback_decoder (table-lookup model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_readback_decoder;

    localparam int         S    = 16;
    localparam logic [6:0] ZERO = 7'b0000001;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [27:0] seg_in  = '1;
    logic        val_ack = 1'b0;
    logic [6:0]  val_value;
    logic        val_err;
    logic        val_valid;
    logic        busy;
`ifdef SEG_DEC_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int err_total = 0;

    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    logic [7:0] pub_q [$];
    logic       prev_valid = 1'b0;

    seg_readback_decoder #(.STABLE_CYCLES(S), .ERRCNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .val_ack   (val_ack),
        .val_value (val_value),
        .val_err   (val_err),
        .val_valid (val_valid),
        .busy      (busy)
`ifdef SEG_DEC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Record every publish ({err, value}) as val_valid rises
    always @(posedge clk) begin
        #2;
        if (val_valid === 1'b1 && prev_valid !== 1'b1) pub_q.push_back({val_err, val_value});
        prev_valid = val_valid;
    end

    function automatic logic [27:0] enc(input int v);
        return {pat[v / 10], pat[v % 10], ZERO, ZERO};
    endfunction

    function automatic logic [7:0] model_decode(input logic [27:0] w);
        int t;
        int o;
        t = -1;
        o = -1;
        for (int i = 0; i < 10; i++) begin
            if (w[27:21] == pat[i]) t = i;
            if (w[20:14] == pat[i]) o = i;
        end
        if (t < 0 || o < 0 || w[13:7] != ZERO || w[6:0] != ZERO) return {1'b1, 7'd0};
        return {1'b0, 7'(t * 10 + o)};
    endfunction

    task automatic wait_valid(input int max, output int k);
        k = 0;
        while (val_valid !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_ack();
        val_ack = 1'b1;
        @(negedge clk);
        val_ack = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        pub_q.delete();
        rst = 1'b1; val_ack = 1'b0; seg_in = enc(57);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (val_valid !== 1'b0 || val_value !== 7'd0 || val_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b value=%0d err=%b busy=%b, required 0/0/0/1",
                     val_valid, val_value, val_err, busy);
        end
`ifdef SEG_DEC_ERRCNT_EN
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_errcnt: got %0d, required 0", err_count);
        end
`endif
        rst = 1'b0;
        wait_valid(S + 10, k);
        n_cmp++;
        if (k != S + 3) begin
            n_fail++; $display("FAIL first_latency: got %0d edges, required %0d", k, S + 3);
        end
        n_cmp++;
        if (val_valid !== 1'b1 || {val_err, val_value} !== {1'b0, 7'd57}) begin
            n_fail++; $display("FAIL first_value: valid=%b err=%b value=%0d, required 1/0/57",
                                val_valid, val_err, val_value);
        end
        do_ack();
        n_cmp++;
        if (val_valid !== 1'b0) begin
            n_fail++; $display("FAIL ack_drop: valid=%b, required 0", val_valid);
        end
        repeat (3 * S) @(negedge clk);
        n_cmp++;
        if (pub_q.size() != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL no_republish: publishes=%0d busy=%b, required 1/0", pub_q.size(), busy);
        end
    endtask

    task automatic test_glitch();
        bit saw_busy;
        bit saw_valid;
        pub_q.delete();
        saw_busy = 0; saw_valid = 0;
        seg_in = enc(42);
        repeat (5) begin
            @(negedge clk);
            saw_busy  |= (busy === 1'b1);
            saw_valid |= (val_valid === 1'b1);
        end
        seg_in = enc(57);
        repeat (2 * S) begin
            @(negedge clk);
            saw_busy  |= (busy === 1'b1);
            saw_valid |= (val_valid === 1'b1);
        end
        n_cmp++;
        if (!saw_busy || saw_valid || busy !== 1'b0 || pub_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch: saw_busy=%0d saw_valid=%0d busy=%b publishes=%0d, required 1/0/0/0",
                     saw_busy, saw_valid, busy, pub_q.size());
        end
    endtask

    task automatic test_change_hold();
        int k;
        bit held_ok;
        pub_q.delete();
        do_ack();
        do_ack();
        seg_in = enc(99);
        wait_valid(S + 10, k);
        n_cmp++;
        if (k != S + 3 || val_valid !== 1'b1 || {val_err, val_value} !== {1'b0, 7'd99}) begin
            n_fail++; $display("FAIL publish_99: edges=%0d valid=%b err=%b value=%0d, required %0d/1/0/99",
                                k, val_valid, val_err, val_value, S + 3);
        end
        seg_in = enc(3);
        held_ok = 1;
        repeat (40) begin
            @(negedge clk);
            if (val_valid !== 1'b1 || val_value !== 7'd99) held_ok = 0;
        end
        n_cmp++;
        if (!held_ok) begin
            n_fail++; $display("FAIL frozen_hold: valid=%b value=%0d, required 1/99 throughout", val_valid, val_value);
        end
        do_ack();
        n_cmp++;
        if (val_valid !== 1'b0) begin
            n_fail++; $display("FAIL ack_drop_99: valid=%b, required 0", val_valid);
        end
        wait_valid(S + 10, k);
        n_cmp++;
        if (val_valid !== 1'b1 || {val_err, val_value} !== {1'b0, 7'd3}) begin
            n_fail++; $display("FAIL publish_03: valid=%b err=%b value=%0d, required 1/0/3",
                                val_valid, val_err, val_value);
        end
        do_ack();
        n_cmp++;
        if (pub_q.size() != 2) begin
            n_fail++; $display("FAIL publish_count_9903: got %0d, required 2", pub_q.size());
        end
    endtask

    task automatic test_errors();
        int k;
        logic [27:0] words [3];
        logic [7:0]  want  [3];
        words[0] = {7'b1111111, pat[5], ZERO, ZERO};  want[0] = {1'b1, 7'd0};
        words[1] = enc(12);                           want[1] = {1'b0, 7'd12};
        words[2] = {pat[1], pat[2], ZERO, 7'b1001111}; want[2] = {1'b1, 7'd0};
        for (int i = 0; i < 3; i++) begin
            seg_in = words[i];
            wait_valid(S + 10, k);
            if (want[i][7]) err_total++;
            n_cmp++;
            if (val_valid !== 1'b1 || {val_err, val_value} !== want[i]) begin
                n_fail++; $display("FAIL err_word%0d: valid=%b err=%b value=%0d, required 1/%b/%0d",
                                    i, val_valid, val_err, val_value, want[i][7], want[i][6:0]);
            end
`ifdef SEG_DEC_ERRCNT_EN
            @(negedge clk);
            n_cmp++;
            if (err_count !== 8'(err_total)) begin
                n_fail++; $display("FAIL errcnt_word%0d: got %0d, required %0d", i, err_count, err_total);
            end
`endif
            do_ack();
        end
    endtask

    task automatic test_err_saturation();
        logic [7:0]  exp_q [$];
        logic [27:0] w;
        int bad;
        pub_q.delete();
        val_ack = 1'b1;
        for (int i = 0; i < 300; i++) begin
            seg_in = enc(12);
            exp_q.push_back({1'b0, 7'd12});
            repeat (S + 5) @(negedge clk);
            w = 28'($urandom);
            w[13:7] = 7'b1111111;
            seg_in = w;
            exp_q.push_back(model_decode(w));
            err_total++;
            repeat (S + 5) @(negedge clk);
        end
        val_ack = 1'b0;
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < pub_q.size(); i++)
            if (bad < 0 && pub_q[i] !== exp_q[i]) bad = i;
        n_cmp++;
        if (pub_q.size() != exp_q.size() || bad >= 0) begin
            n_fail++; $display("FAIL alternation: publishes=%0d first_bad=%0d, required %0d publishes all matching",
                                pub_q.size(), bad, exp_q.size());
        end
`ifdef SEG_DEC_ERRCNT_EN
        n_cmp++;
        if (err_count !== 8'd255) begin
            n_fail++; $display("FAIL errcnt_saturate: got %0d, required 255", err_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int k;
        seg_in = enc(88);
        wait_valid(S + 10, k);
        n_cmp++;
        if (val_valid !== 1'b1 || {val_err, val_value} !== {1'b0, 7'd88}) begin
            n_fail++; $display("FAIL pre_reset_88: valid=%b value=%0d, required 1/88", val_valid, val_value);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (val_valid !== 1'b0 || val_value !== 7'd0) begin
            n_fail++; $display("FAIL mid_reset: valid=%b value=%0d, required 0/0", val_valid, val_value);
        end
`ifdef SEG_DEC_ERRCNT_EN
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset_errcnt: got %0d, required 0", err_count);
        end
`endif
        rst = 1'b0;
        err_total = 0;
        wait_valid(S + 10, k);
        n_cmp++;
        if (k != S + 3 || val_valid !== 1'b1 || val_value !== 7'd88) begin
            n_fail++; $display("FAIL republish_88: edges=%0d valid=%b value=%0d, required %0d/1/88",
                                k, val_valid, val_value, S + 3);
        end
        do_ack();
    endtask

    task automatic test_random();
        logic [7:0]  exp_q [$];
        logic [7:0]  last;
        logic [7:0]  dec;
        logic [27:0] w;
        logic [27:0] cur;
        bit long_seg;
        int d;
        int bad;
        pub_q.delete();
        last = {1'b0, 7'd88};
        cur  = enc(88);
        val_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do begin
                if ($urandom_range(0, 9) < 7) w = enc(int'($urandom_range(0, 99)));
                else                          w = 28'($urandom);
            end while (w == cur);
            long_seg = (i == 39) || ($urandom_range(0, 1) == 1);
            d = long_seg ? int'($urandom_range(S + 5, S + 12)) : int'($urandom_range(1, S - 2));
            seg_in = w;
            cur = w;
            repeat (d) @(negedge clk);
            if (long_seg) begin
                dec = model_decode(w);
                if (dec != last) begin
                    exp_q.push_back(dec);
                    last = dec;
                    if (dec[7]) err_total++;
                end
            end
        end
        repeat (5) @(negedge clk);
        val_ack = 1'b0;
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < pub_q.size(); i++)
            if (bad < 0 && pub_q[i] !== exp_q[i]) bad = i;
        n_cmp++;
        if (pub_q.size() != exp_q.size() || bad >= 0) begin
            n_fail++; $display("FAIL random_stream: publishes=%0d first_bad=%0d, required %0d publishes all matching",
                                pub_q.size(), bad, exp_q.size());
        end
`ifdef SEG_DEC_ERRCNT_EN
        n_cmp++;
        if (err_count !== 8'(err_total)) begin
            n_fail++; $display("FAIL random_errcnt: got %0d, required %0d", err_count, err_total);
        end
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_glitch();
        test_change_hold();
        test_errors();
        test_err_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
